// File: rtl/exec_ctrl.sv
// exec_ctrl
// Execution controller for the multicycle RISC-V core. Generates the CPU clock
// (ClockDIV = CLOCK/2 while active, held low while stopped) and decides, at
// every CLOCK edge where ClockDIV is low, whether the core gets another period.
// Supports free run, single-instruction step, external halt and a PC
// breakpoint, and counts CPU cycles and fetched instructions.
//
// Ports
//   CLOCK      in   system clock (also the memory clock)
//   Reset      in   synchronous, active-high, shared with the CPU
//   Run        in   level: free-run request; rising edge resumes from halt
//   Step       in   rising edge: execute one instruction while halted
//   Halt       in   level: stop at next period boundary, highest priority
//   BrkEn      in   breakpoint enable
//   BrkAddr    in   breakpoint PC
//   PC         in   current CPU PC
//   Estado     in   current CPU FSM state
//   ClockDIV   out  CPU clock
//   Halted     out  high while in HALT
//   CtrlState  out  00 HALT, 01 RUN, 10 STEP
//   CycleCount out  ClockDIV rising edges since reset
//   InstrCount out  instruction fetches started since reset
module exec_ctrl #(
  parameter logic [3:0] FETCH_STATE = 4'd0
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Step,
  input  logic        Halt,
  input  logic        BrkEn,
  input  logic [31:0] BrkAddr,
  input  logic [31:0] PC,
  input  logic [3:0]  Estado,
  output logic        ClockDIV,
  output logic        Halted,
  output logic [1:0]  CtrlState,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        clkdiv_q, clkdiv_d;
  logic        skip_q, skip_d;
  logic        stepped_q, stepped_d;
  logic        run_q, step_q;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ins_q, ins_d;

  logic run_e, step_e, fb, brk_hit, start;

  assign run_e   = Run & ~run_q;
  assign step_e  = Step & ~step_q;
  assign fb      = (Estado == FETCH_STATE);
  // skip lets a resume from a breakpoint execute the breakpointed instruction
  assign brk_hit = BrkEn & fb & (PC == BrkAddr) & ~skip_q;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    stepped_d = stepped_q;
    start     = 1'b0;
    // A high phase always completes; decisions are only taken while low.
    if (!clkdiv_q) begin
      unique case (state_q)
        S_HALT: begin
          if (Halt) begin
            state_d = S_HALT;
          end else if (step_e) begin
            state_d   = S_STEP;
            start     = 1'b1;
            stepped_d = 1'b0;
          end else if (run_e) begin
            state_d = S_RUN;
            start   = 1'b1;
            skip_d  = 1'b1;
          end
        end
        S_RUN: begin
          if (Halt || !Run) begin
            state_d = S_HALT;
          end else if (brk_hit) begin
            state_d = S_HALT;
          end else begin
            start  = 1'b1;
            skip_d = 1'b0;
          end
        end
        S_STEP: begin
          if (Halt) begin
            state_d = S_HALT;
          end else if (fb && stepped_q) begin
            state_d = S_HALT;
          end else begin
            start     = 1'b1;
            stepped_d = 1'b1;
          end
        end
        default: state_d = S_HALT;
      endcase
    end
    clkdiv_d = start;
    cyc_d    = cyc_q + {31'd0, start};
    ins_d    = ins_q + {31'd0, start & fb};
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state_q   <= S_HALT;
      clkdiv_q  <= 1'b0;
      skip_q    <= 1'b0;
      stepped_q <= 1'b0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      cyc_q     <= 32'd0;
      ins_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      clkdiv_q  <= clkdiv_d;
      skip_q    <= skip_d;
      stepped_q <= stepped_d;
      run_q     <= Run;
      step_q    <= Step;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

  assign ClockDIV   = clkdiv_q;
  assign Halted     = (state_q == S_HALT);
  assign CtrlState  = state_q;
  assign CycleCount = cyc_q;
  assign InstrCount = ins_q;

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;

  logic        CLOCK = 1'b0;
  logic        Reset;
  logic        Run, Step, Halt, BrkEn;
  logic [31:0] BrkAddr;
  logic        ClockDIV, Halted;
  logic [1:0]  CtrlState;
  logic [31:0] CycleCount, InstrCount;

  // Mock multicycle core: Estado cycles 0..3 per CPU period, PC += 4 per instruction
  logic [3:0]  estado;
  logic [31:0] pc;

  int tests = 0;
  int fails = 0;
  int rises = 0;
  int r0;
  int n;

  exec_ctrl #(.FETCH_STATE(4'd0)) dut (
    .CLOCK      (CLOCK),
    .Reset      (Reset),
    .Run        (Run),
    .Step       (Step),
    .Halt       (Halt),
    .BrkEn      (BrkEn),
    .BrkAddr    (BrkAddr),
    .PC         (pc),
    .Estado     (estado),
    .ClockDIV   (ClockDIV),
    .Halted     (Halted),
    .CtrlState  (CtrlState),
    .CycleCount (CycleCount),
    .InstrCount (InstrCount)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge ClockDIV or posedge Reset) begin
    if (Reset) begin
      estado <= 4'd0;
      pc     <= 32'd0;
    end else begin
      estado <= (estado == 4'd3) ? 4'd0 : estado + 4'd1;
      if (estado == 4'd3) pc <= pc + 32'd4;
    end
  end

  always @(posedge ClockDIV) rises <= rises + 1;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b0; Step = 1'b0; Halt = 1'b0; BrkEn = 1'b0; BrkAddr = 32'd0;
    #1 Reset = 1'b1;

    // Reset held with Run low
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_clkdiv", {31'd0, ClockDIV}, 32'd0);
      check("rst_halted", {31'd0, Halted}, 32'd1);
      check("rst_state", {30'd0, CtrlState}, 32'd0);
      check("rst_cyc", CycleCount, 32'd0);
      check("rst_ins", InstrCount, 32'd0);
    end

    // Run held through reset release: period starts on first edge after reset
    Run = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    check("run_first_clk", {31'd0, ClockDIV}, 32'd1);
    check("run_state", {30'd0, CtrlState}, 32'd1);
    repeat (39) tick();
    check("run40_cyc", CycleCount, 32'd20);
    check("run40_ins", InstrCount, 32'd5);
    check("run40_clk", {31'd0, ClockDIV}, 32'd0);

    // Stop by dropping Run (ClockDIV already low -> halts on next edge)
    Run = 1'b0;
    tick();
    check("stop_halted", {31'd0, Halted}, 32'd1);
    check("stop_cyc", CycleCount, 32'd20);

    // Single step: 4 CPU periods, Halted rises 8 edges after step edge
    r0 = rises;
    Step = 1'b1;
    tick();
    Step = 1'b0;
    check("step_state", {30'd0, CtrlState}, 32'd2);
    check("step_clk", {31'd0, ClockDIV}, 32'd1);
    repeat (7) tick();
    check("step_not_yet", {31'd0, Halted}, 32'd0);
    tick();
    check("step_halted", {31'd0, Halted}, 32'd1);
    check("step_rises", rises - r0, 32'd4);
    check("step_ins", InstrCount, 32'd6);
    check("step_cyc", CycleCount, 32'd24);
    check("step_estado", {28'd0, estado}, 32'd0);
    repeat (3) tick();
    check("step_stays", rises - r0, 32'd4);

    // Breakpoint at 0x10 from a fresh start
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    BrkEn = 1'b1; BrkAddr = 32'h10; Run = 1'b1;
    tick();
    n = 1;
    while (!Halted && n < 100) begin
      tick();
      n++;
    end
    check("brk_halted", {31'd0, Halted}, 32'd1);
    check("brk_edges", n, 32'd33);
    check("brk_pc", pc, 32'h10);
    check("brk_estado", {28'd0, estado}, 32'd0);
    check("brk_ins", InstrCount, 32'd4);
    check("brk_cyc", CycleCount, 32'd16);

    // Resume via Run low then high: executes 0x10 without re-halting
    Run = 1'b0;
    tick();
    Run = 1'b1;
    tick();
    check("resume_clk", {31'd0, ClockDIV}, 32'd1);
    check("resume_state", {30'd0, CtrlState}, 32'd1);
    repeat (9) tick();
    check("resume_pc", pc, 32'h14);
    check("resume_running", {31'd0, Halted}, 32'd0);
    check("resume_ins", InstrCount, 32'd6);
    check("resume_cyc", CycleCount, 32'd21);

    // Halt while ClockDIV high: period completes, no further rising edge
    tick();
    check("pre_halt_clk", {31'd0, ClockDIV}, 32'd1);
    r0 = rises;
    Halt = 1'b1;
    tick();
    check("halt_fall", {31'd0, ClockDIV}, 32'd0);
    Step = 1'b1;
    tick();
    check("halt_halted", {31'd0, Halted}, 32'd1);
    Step = 1'b0;
    tick();
    Step = 1'b1;
    tick();
    check("halt_step_ignored", {30'd0, CtrlState}, 32'd0);
    Step = 1'b0;
    tick();
    check("halt_no_rise", rises - r0, 32'd0);
    check("halt_cyc", CycleCount, 32'd22);
    Halt = 1'b0;

    // Reset mid-step while ClockDIV high
    Run = 1'b0;
    tick();
    Step = 1'b1;
    tick();
    Step = 1'b0;
    check("midstep_clk", {31'd0, ClockDIV}, 32'd1);
    check("midstep_state", {30'd0, CtrlState}, 32'd2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mrst_clk", {31'd0, ClockDIV}, 32'd0);
    check("mrst_halted", {31'd0, Halted}, 32'd1);
    check("mrst_cyc", CycleCount, 32'd0);
    check("mrst_ins", InstrCount, 32'd0);

    // Step pulse during RUN is ignored
    Run = 1'b1;
    tick();
    check("run2_cyc1", CycleCount, 32'd1);
    tick();
    Step = 1'b1;
    tick();
    check("run2_step_ign", {30'd0, CtrlState}, 32'd1);
    check("run2_cyc2", CycleCount, 32'd2);
    Step = 1'b0;
    tick();
    tick();
    check("run2_cyc3", CycleCount, 32'd3);
    check("run2_clk", {31'd0, ClockDIV}, 32'd1);
    check("run2_state", {30'd0, CtrlState}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execution controller that generates the CPU clock (`ClockDIV`) for the multicycle RISC-V core and decides when the core may advance. It supports free run, single-instruction step, external halt and a PC breakpoint, and it counts executed CPU cycles and instructions. It sits in the top level in place of the free-running `ClockDIV` divider. It observes the core's `PC` and `Estado` to detect instruction boundaries.

## Interface
- `FETCH_STATE`, default 4'd0: the `Estado` code of the multicycle FSM's fetch state.
- `CLOCK` in 1: system clock, which is also the memory clock.
- `Reset` in 1: synchronous, active-high, shared with the CPU.
- `Run` in 1: level input requesting free run. A rising edge resumes from halt.
- `Step` in 1: a rising edge requests one instruction while halted.
- `Halt` in 1: level input. Forces a stop at the next period boundary and has priority over `Run` and `Step`.
- `BrkEn` in 1: enables the breakpoint.
- `BrkAddr` in 32: breakpoint PC.
- `PC` in 32: current CPU PC.
- `Estado` in 4: current CPU FSM state.
- `ClockDIV` out 1: CPU clock, CLOCK/2 while active, held at 0 while stopped.
- `Halted` out 1: high when the controller is in HALT.
- `CtrlState` out 2: 00 = HALT, 01 = RUN, 10 = STEP.
- `CycleCount` out 32: number of ClockDIV rising edges since reset.
- `InstrCount` out 32: number of instruction fetches started since reset.

## Operation
- Edge detectors register `run_q` and `step_q`, both reset to 0. The edges are `run_e = Run & ~run_q` and `step_e = Step & ~step_q`.
- When `ClockDIV == 1`, it always toggles to 0 on the next edge. A period is never truncated.
- A decision point is any CLOCK edge where `ClockDIV == 0`. "Start a period" means `ClockDIV <= 1`.
- Fetch boundary `fb = (Estado == FETCH_STATE)`, sampled at a decision point.
- HALT state, at each decision point:
  - If `Halt`: stay in HALT.
  - Else if `step_e`: go to STEP, start a period, clear `stepped`.
  - Else if `run_e`: go to RUN, start a period, set `skip`.
  - Else stay, with `ClockDIV` held at 0.
- RUN state, at each decision point:
  - If `Halt | ~Run`: go to HALT with no period.
  - Else if `BrkEn & fb & (PC == BrkAddr) & ~skip`: go to HALT, the breakpoint hit.
  - Else start a period and clear `skip`.
- STEP state, at each decision point:
  - If `Halt`: go to HALT.
  - Else if `fb & stepped`: go to HALT.
  - Else start a period and set `stepped`.
  - Breakpoints are ignored in STEP.
- The `skip` flag lets a resume from a breakpoint execute the breakpointed instruction. It applies only to the first decision point after entering RUN.
- `step_e` and `run_e` are ignored outside HALT, and any edge that is not consumed is lost.
- Counters:
  - On every period start, `CycleCount` increments by 1.
  - If `fb` is also true at that period start, `InstrCount` increments by 1.
  - Both counters wrap modulo 2^32.
- Reset values: `ClockDIV` = 0, state = HALT (`Halted` = 1, `CtrlState` = 00), both counters = 0, and `skip`, `stepped`, `run_q`, `step_q` all 0.
- Reset mid-operation takes effect at the next edge regardless of the `ClockDIV` phase. `ClockDIV` is forced to 0 even if it is high.
- Because `run_q` resets to 0, a `Run` held high through reset produces `run_e` on the first edge after reset.

## Timing
- Latency from an edge on `run_e` or `step_e` in HALT to `ClockDIV` going high is 1 CLOCK edge. The state change happens on that same edge.
- While active, `ClockDIV` has a period of 2 CLOCK cycles at 50 % duty, starting high.
- The stop latency after `Halt` or `~Run` is at most 2 CLOCK edges. `Halted` rises on the edge where `ClockDIV` is already 0.
- A step costs exactly N CPU periods, where N is the number of FSM states in the current instruction. `Halted` rises 2N CLOCK edges after `step_e`.
- `PC`, `Estado`, `Halt`, `Run` and `Step` are sampled only on CLOCK rising edges.

## Test plan
- Reset with `Run` = 0 for 10 CLOCK cycles: `ClockDIV` = 0, `Halted` = 1, `CtrlState` = 00, and both counters = 0 throughout.
- Release reset with `Run` held at 1 and a mock FSM that cycles `Estado` 0→1→2→3 per period: `ClockDIV` goes high 1 edge after reset deasserts. After 40 CLOCK edges, `CycleCount` = 20 and `InstrCount` = 5.
- Halted, then a 1-cycle `Step` pulse with the same mock: exactly 4 `ClockDIV` rising edges, then `Halted` = 1. `InstrCount` rises by 1 and `Estado` = 0 at the stop.
- `BrkEn` = 1, `BrkAddr` = 0x10, mock PC advances by 4 per instruction from 0:
  - The core halts with PC = 0x10, `Estado` = 0 and `InstrCount` = 4.
  - Pulling `Run` low and then high resumes: PC reaches 0x14 and there is no re-halt at 0x10.
- Assert `Halt` while `ClockDIV` = 1 in RUN: `ClockDIV` falls on the next edge, with no further rising edge. `Halted` = 1 within 2 edges, and a `Step` edge while `Halt` is held is ignored.
- Assert `Reset` for 1 cycle while `ClockDIV` = 1 mid-step: the next edge gives `ClockDIV` = 0, HALT and counters = 0. A `Step` pulse issued during RUN is ignored, leaving the `CycleCount` sequence unchanged.
